// File: rtl/l1b_getir_yanitlayici_if.sv
// Fetch-side handshake bundle for l1b_getir_yanitlayici: stage 1 requests,
// stage 2 instruction words, instruction memory port and pipeline flush.
interface l1b_getir_yanitlayici_if #(
    parameter int unsigned ADRES_BIT = 32
);
    logic [ADRES_BIT-1:0] g1_istek_ps_i;
    logic                 g1_istek_gecerli_i;
    logic                 g1_istek_hazir_o;
    logic [31:0]          g2_buyruk_o;
    logic                 g2_buyruk_gecerli_o;
    logic                 g2_buyruk_hazir_i;
    logic [ADRES_BIT-1:0] bellek_istek_adres_o;
    logic                 bellek_istek_gecerli_o;
    logic                 bellek_istek_hazir_i;
    logic [31:0]          bellek_yanit_veri_i;
    logic                 bellek_yanit_gecerli_i;
    logic                 bosalt_i;

    modport slave (
        input  g1_istek_ps_i, g1_istek_gecerli_i, g2_buyruk_hazir_i,
        input  bellek_istek_hazir_i, bellek_yanit_veri_i, bellek_yanit_gecerli_i,
        input  bosalt_i,
        output g1_istek_hazir_o, g2_buyruk_o, g2_buyruk_gecerli_o,
        output bellek_istek_adres_o, bellek_istek_gecerli_o
    );

    modport master (
        output g1_istek_ps_i, g1_istek_gecerli_i, g2_buyruk_hazir_i,
        output bellek_istek_hazir_i, bellek_yanit_veri_i, bellek_yanit_gecerli_i,
        output bosalt_i,
        input  g1_istek_hazir_o, g2_buyruk_o, g2_buyruk_gecerli_o,
        input  bellek_istek_adres_o, bellek_istek_gecerli_o
    );
endinterface

// File: rtl/l1b_getir_yanitlayici.sv
// Instruction-side L1 responder: credit-limited memory reads, in-order response
// FIFO, flush drop counter. Optional last-word buffer under `L1B_SON_SATIR_EN.
module l1b_getir_yanitlayici #(
    parameter int unsigned KUYRUK_DERINLIK = 4,
    parameter int unsigned ADRES_BIT       = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    l1b_getir_yanitlayici_if.slave        bag
);
    localparam int unsigned SAYAC_BIT = $clog2(KUYRUK_DERINLIK) + 1;
    localparam int unsigned PTR_BIT   = $clog2(KUYRUK_DERINLIK);
    localparam logic [SAYAC_BIT:0] DERINLIK_G = (SAYAC_BIT+1)'(KUYRUK_DERINLIK);

    logic [SAYAC_BIT-1:0] ucusta, doluluk, atilacak;
    logic [SAYAC_BIT:0]   toplam;
    logic [PTR_BIT-1:0]   yaz_ptr, oku_ptr;
    logic [31:0]          kuyruk [KUYRUK_DERINLIK];

    logic                 kredi, isabet, bellek_kabul, yanit_al, push, pop;
    logic [31:0]          push_veri;
    logic [ADRES_BIT-1:0] hizali_adres;

    assign toplam       = {1'b0, ucusta} + {1'b0, doluluk};
    assign kredi        = toplam < DERINLIK_G;
    assign hizali_adres = {bag.g1_istek_ps_i[ADRES_BIT-1:2], 2'b00};

    assign bag.bellek_istek_adres_o   = hizali_adres;
    assign bag.bellek_istek_gecerli_o = bag.g1_istek_gecerli_i && kredi && !bag.bosalt_i && !isabet;
    assign bag.g1_istek_hazir_o       = isabet || (bag.bellek_istek_hazir_i && kredi && !bag.bosalt_i);

    assign bellek_kabul = bag.bellek_istek_gecerli_o && bag.bellek_istek_hazir_i;
    assign yanit_al     = bag.bellek_yanit_gecerli_i && (ucusta != '0);
    assign pop          = bag.g2_buyruk_gecerli_o && bag.g2_buyruk_hazir_i;
    // A hit only happens with nothing in flight, so it never collides with a memory push.
    assign push         = !bag.bosalt_i && ((yanit_al && atilacak == '0) || isabet);

    assign bag.g2_buyruk_gecerli_o = doluluk != '0;
    assign bag.g2_buyruk_o         = bag.g2_buyruk_gecerli_o ? kuyruk[oku_ptr] : '0;

`ifdef L1B_SON_SATIR_EN
    logic                 son_gecerli;
    logic [ADRES_BIT-1:0] son_adres;
    logic [31:0]          son_veri;
    logic [ADRES_BIT-1:0] ucan_adres [KUYRUK_DERINLIK];
    logic [PTR_BIT-1:0]   a_yaz, a_oku;

    assign isabet    = bag.g1_istek_gecerli_i && !bag.bosalt_i && son_gecerli &&
                       (hizali_adres == son_adres) && (ucusta == '0) && kredi;
    assign push_veri = isabet ? son_veri : bag.bellek_yanit_veri_i;

    // Addresses of in-flight reads, so a returning word can be tagged for the buffer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_yaz <= '0;
            a_oku <= '0;
        end else begin
            if (bellek_kabul) a_yaz <= a_yaz + 1'b1;
            if (yanit_al)     a_oku <= a_oku + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (bellek_kabul) ucan_adres[a_yaz] <= hizali_adres;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || bag.bosalt_i) begin
            son_gecerli <= 1'b0;
            son_adres   <= '0;
            son_veri    <= '0;
        end else if (push && !isabet) begin
            son_gecerli <= 1'b1;
            son_adres   <= ucan_adres[a_oku];
            son_veri    <= bag.bellek_yanit_veri_i;
        end
    end
`else
    assign isabet    = 1'b0;
    assign push_veri = bag.bellek_yanit_veri_i;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ucusta   <= '0;
            doluluk  <= '0;
            atilacak <= '0;
            yaz_ptr  <= '0;
            oku_ptr  <= '0;
        end else begin
            case ({bellek_kabul, yanit_al})
                2'b10:   ucusta <= ucusta + 1'b1;
                2'b01:   ucusta <= ucusta - 1'b1;
                default: ucusta <= ucusta;
            endcase

            // Every read still owed after a flush is dropped; already-counted drops
            // are part of ucusta, so the new drop count is just what remains in flight.
            if (bag.bosalt_i)
                atilacak <= yanit_al ? ucusta - 1'b1 : ucusta;
            else if (yanit_al && atilacak != '0)
                atilacak <= atilacak - 1'b1;

            if (bag.bosalt_i) begin
                doluluk <= '0;
                yaz_ptr <= '0;
                oku_ptr <= '0;
            end else begin
                case ({push, pop})
                    2'b10:   doluluk <= doluluk + 1'b1;
                    2'b01:   doluluk <= doluluk - 1'b1;
                    default: doluluk <= doluluk;
                endcase
                if (push) yaz_ptr <= yaz_ptr + 1'b1;
                if (pop)  oku_ptr <= oku_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) kuyruk[yaz_ptr] <= push_veri;
    end
endmodule
